// File: rtl/relay_seq_fsm.sv
// Instruction-cycle sequencer for the relay computer: registered one-hot machine-state vector.
// Optional build macro SEQ_ILLEGAL_TRAP_EN: illegal opcodes set 'illegal' and halt like HALT.
module relay_seq_fsm #(
    parameter int NUM_STATES = 24,
    parameter int FETCH_LEN  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  step,
    input  logic                  clear,
    input  logic [7:0]            inst_reg_value,
    output logic [NUM_STATES-1:0] state_onehot,
    output logic                  busy,
    output logic                  instr_done,
    output logic                  halted,
    output logic                  illegal
);
    // state  | meaning
    // IDLE   | no instruction in progress, waiting for run or step
    // EXEC   | one-hot state vector walking state_1..state_LEN
    // HALTED | HALT (or trapped illegal) completed, waiting for clear
    typedef enum logic [1:0] {IDLE, EXEC, HALTED} ctrl_t;

    localparam int LW = $clog2(NUM_STATES + 1);

    ctrl_t         ctrl;
    logic [LW-1:0] len;
    logic          stop_op;

    function automatic logic [LW-1:0] decode_len(input logic [7:0] ir);
        logic [LW-1:0] l;
        casez (ir)
            8'b0???????: l = LW'(8);
            8'b11??????: l = LW'(NUM_STATES);
            8'b1000????: l = LW'(8);
            8'b1001????: l = LW'(12);
            8'b10100000: l = LW'(10);
            8'b10110000: l = LW'(14);
            default:     l = LW'(8);
        endcase
        return l;
    endfunction

    function automatic logic is_halt(input logic [7:0] ir);
        return ir == 8'hAE;
    endfunction

`ifdef SEQ_ILLEGAL_TRAP_EN
    function automatic logic is_illegal(input logic [7:0] ir);
        return (ir[7:5] == 3'b101) && (ir != 8'hA0) && (ir != 8'hB0) && (ir != 8'hAE);
    endfunction
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl         <= IDLE;
            state_onehot <= '0;
            busy         <= 1'b0;
            instr_done   <= 1'b0;
            halted       <= 1'b0;
            len          <= LW'(8);
            stop_op      <= 1'b0;
`ifdef SEQ_ILLEGAL_TRAP_EN
            illegal      <= 1'b0;
`endif
        end else if (clear) begin
            ctrl         <= IDLE;
            state_onehot <= '0;
            busy         <= 1'b0;
            instr_done   <= 1'b0;
            halted       <= 1'b0;
            len          <= LW'(8);
            stop_op      <= 1'b0;
`ifdef SEQ_ILLEGAL_TRAP_EN
            illegal      <= 1'b0;
`endif
        end else begin
            case (ctrl)
                IDLE: begin
                    if (!halted && (run || step)) begin
                        ctrl         <= EXEC;
                        state_onehot <= NUM_STATES'(1);
                        busy         <= 1'b1;
                    end
                end
                EXEC: begin
                    if (instr_done) begin
                        instr_done <= 1'b0;
                        if (stop_op) begin
                            ctrl         <= HALTED;
                            state_onehot <= '0;
                            busy         <= 1'b0;
                            halted       <= 1'b1;
                        end else if (run) begin
                            state_onehot <= NUM_STATES'(1);
                        end else begin
                            ctrl         <= IDLE;
                            state_onehot <= '0;
                            busy         <= 1'b0;
                        end
                    end else begin
                        state_onehot <= state_onehot << 1;
                        // LEN is at least 8, so a stale LEN can never fire during fetch
                        instr_done   <= state_onehot[len - LW'(2)];
                        if (state_onehot[FETCH_LEN-1]) begin
                            len <= decode_len(inst_reg_value);
`ifdef SEQ_ILLEGAL_TRAP_EN
                            stop_op <= is_halt(inst_reg_value) | is_illegal(inst_reg_value);
                            if (is_illegal(inst_reg_value))
                                illegal <= 1'b1;
`else
                            stop_op <= is_halt(inst_reg_value);
`endif
                        end
                    end
                end
                HALTED: ;
                default: ctrl <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_relay_seq_fsm.sv
// Directed bench for relay_seq_fsm: vector table plus hand sequences for multi-cycle corners.
module tb_relay_seq_fsm;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0, step = 1'b0, clear = 1'b0;
    logic [7:0]  inst_reg_value = 8'h00;
    logic [23:0] state_onehot;
    logic        busy, instr_done, halted, illegal;

    int total = 0;
    int bad = 0;

    relay_seq_fsm dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .clear(clear),
        .inst_reg_value(inst_reg_value), .state_onehot(state_onehot),
        .busy(busy), .instr_done(instr_done), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        run, step, clr;
        logic [7:0]  ir;
        logic [23:0] oh;
        logic        busy, done, halted;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic c, input logic [7:0] ir,
                       input logic [23:0] oh, input logic b, input logic d, input logic h);
        vec_t v;
        v.run = r; v.step = s; v.clr = c; v.ir = ir;
        v.oh = oh; v.busy = b; v.done = d; v.halted = h;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string name, input logic [23:0] oh, input logic d);
        check({name, " onehot"}, 32'(state_onehot), 32'(oh));
        check({name, " done"}, 32'(instr_done), 32'(d));
        check({name, " busy"}, 32'(busy), 32'(oh != 0));
    endtask

    initial begin
        // MOV8 back to back, then HALT, halted state, clear, restart, clear mid-instruction
        add(1, 0, 0, 8'h12, 24'h000001, 1, 0, 0);
        for (int k = 2; k <= 8; k++) add(1, 0, 0, 8'h12, 24'(1) << (k - 1), 1, k == 8, 0);
        add(1, 0, 0, 8'hAE, 24'h000001, 1, 0, 0);
        for (int k = 2; k <= 8; k++) add(1, 0, 0, 8'hAE, 24'(1) << (k - 1), 1, k == 8, 0);
        add(1, 0, 0, 8'h00, 24'h0, 0, 0, 1);
        add(1, 0, 0, 8'h00, 24'h0, 0, 0, 1);
        add(0, 1, 0, 8'h00, 24'h0, 0, 0, 1);
        add(1, 0, 1, 8'h00, 24'h0, 0, 0, 0);
        add(1, 0, 0, 8'h12, 24'h000001, 1, 0, 0);
        add(1, 0, 0, 8'h12, 24'h000002, 1, 0, 0);
        add(1, 0, 1, 8'h12, 24'h0, 0, 0, 0);
        add(0, 0, 0, 8'h12, 24'h0, 0, 0, 0);

        #23;
        check("reset onehot", 32'(state_onehot), 0);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(instr_done), 0);
        check("reset halted", 32'(halted), 0);
        check("reset illegal", 32'(illegal), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle after reset", 32'(state_onehot), 0);

        foreach (vecs[i]) begin
            run = vecs[i].run; step = vecs[i].step; clear = vecs[i].clr;
            inst_reg_value = vecs[i].ir;
            tick();
            check($sformatf("vec%0d onehot", i), 32'(state_onehot), 32'(vecs[i].oh));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("vec%0d done", i), 32'(instr_done), 32'(vecs[i].done));
            check($sformatf("vec%0d halted", i), 32'(halted), 32'(vecs[i].halted));
        end
        run = 0; step = 0; clear = 0;

        // GOTO: 24 states, IR change after the latch is ignored
        run = 1; inst_reg_value = 8'hC0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            check_state($sformatf("goto s%0d", k), 24'(1) << (k - 1), k == 24);
            if (k == 10) inst_reg_value = 8'h00;
        end
        run = 0;
        tick();
        check_state("goto end", 24'h0, 0);

        // LOAD by single step; a second step at state_5 is dropped
        step = 1; inst_reg_value = 8'h90;
        tick();
        step = 0;
        check_state("load s1", 24'h000001, 0);
        for (int k = 2; k <= 12; k++) begin
            tick();
            step = 0;
            check_state($sformatf("load s%0d", k), 24'(1) << (k - 1), k == 12);
            if (k == 5) step = 1;
        end
        tick();
        check_state("load end", 24'h0, 0);
        tick();
        check_state("load stays idle", 24'h0, 0);

        // INCXY with run dropped at state_6
        run = 1; inst_reg_value = 8'hB0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            check_state($sformatf("incxy s%0d", k), 24'(1) << (k - 1), k == 14);
            if (k == 6) run = 0;
        end
        tick();
        check_state("incxy end", 24'h0, 0);

        // async reset in the middle of a LOAD
        run = 1; inst_reg_value = 8'h90;
        for (int k = 1; k <= 9; k++) tick();
        check("pre-reset s9", 32'(state_onehot), 32'h100);
        #2 rst_n = 1'b0;
        #1;
        check_state("async reset", 24'h0, 0);
        check("async reset halted", 32'(halted), 0);
        run = 0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post-reset idle", 32'(state_onehot), 0);

        // illegal opcode 0xA5
        run = 1; inst_reg_value = 8'hA5;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_state($sformatf("ill s%0d", k), 24'(1) << (k - 1), k == 8);
`ifdef SEQ_ILLEGAL_TRAP_EN
            check($sformatf("ill flag s%0d", k), 32'(illegal), 32'(k >= 4));
`else
            check($sformatf("ill flag s%0d", k), 32'(illegal), 0);
`endif
        end
        tick();
`ifdef SEQ_ILLEGAL_TRAP_EN
        check_state("ill trap", 24'h0, 0);
        check("ill trap halted", 32'(halted), 1);
        check("ill trap flag", 32'(illegal), 1);
        clear = 1;
        tick();
        clear = 0; run = 0;
        check("ill clear halted", 32'(halted), 0);
        check("ill clear flag", 32'(illegal), 0);
`else
        check_state("ill next fetch", 24'h000001, 0);
        check("ill no halt", 32'(halted), 0);
        check("ill flag low", 32'(illegal), 0);
        run = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
